pbkdf2_host: RTL and testbench
==============================

PBKDF2_HOST -- requirements
Module: pbkdf2_host

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i (input, 1, rising-edge clock) and rst_i (input, 1, synchronous active-high reset).
REQ-002 The host configuration port SHALL be:
- cfg_v_i (in, 1): config word valid.
- cfg_r_o (out, 1): config word ready.
- cfg_sel_i (in, 2): 0 = pass word, 1 = salt word, 2 = iters, 3 = go.
- cfg_data_i (in, 32): config word data.
REQ-003 The core request port SHALL be:
- core_in_valid_o (out, 1): request valid.
- core_in_ready_i (in, 1): request ready.
- core_iters_o (out, 32): iteration count.
- core_pass_o (out, 512): password.
- core_salt_o (out, 512): salt.
- core_salt_len_o (out, 6): salt length in bytes.
REQ-004 The core result port SHALL be:
- core_out_valid_i (in, 1): result valid.
- core_out_ready_o (out, 1): result ready.
- core_hash_i (in, 256): derived key.
REQ-005 The result stream port SHALL be:
- res_v_o (out, 1): result word valid.
- res_r_i (in, 1): result word ready.
- res_data_o (out, 32): result word.
- res_last_o (out, 1): final word of the stream.
REQ-006 The status port SHALL be:
- busy_o (out, 1): state is not LOAD.
- err_o (out, 1): one-cycle pulse on a rejected go.

Function
REQ-007 The FSM SHALL have exactly four states: LOAD, ISSUE, WAIT and SEND.
REQ-008 A transfer SHALL occur on any port only in a cycle where its valid and ready are both high.
REQ-009 cfg_r_o SHALL be 1 only in LOAD.
REQ-010 In LOAD, a sel=0 transfer SHALL shift pass left by 32 and insert cfg_data_i into bits [31:0].
- The first of 16 words therefore ends up in [511:480].
- A 17th word SHALL discard the oldest word; no error is raised.
REQ-011 A sel=1 transfer SHALL shift salt identically to pass.
REQ-012 A sel=2 transfer SHALL load iters from cfg_data_i.
REQ-013 A sel=3 (go) transfer SHALL latch salt_len from cfg_data_i[5:0] and then act on iters:
- iters != 0: next state is ISSUE.
- iters == 0: err_o pulses high for 1 cycle, and the state stays LOAD.
REQ-014 In ISSUE, core_in_valid_o SHALL be 1 with core_* data driven from the latched registers, held stable until core_in_ready_i is seen high.
- The cycle after the handshake, the state SHALL become WAIT.
REQ-015 core_in_valid_o SHALL be 0 in every state other than ISSUE.
REQ-016 core_out_ready_o SHALL be 1 only in WAIT.
- On a core_out_valid_i handshake, the block SHALL capture core_hash_i into a 256-bit result register and move to SEND.
REQ-017 In SEND, res_v_o SHALL be 1, and res_data_o SHALL equal result word k = hash[255-32k -: 32], starting at k = 0.
- k SHALL come from a 3-bit counter that advances only on a res handshake.
REQ-018 res_last_o SHALL be 1 on the final word of the stream.
- On the final-word handshake, the block SHALL return to LOAD and clear k to 0.
REQ-019 pass, salt, iters and salt_len SHALL be retained after a job completes, so a new go reruns the same job.
REQ-020 Stall timing:
- A result-port stall SHALL hold res_data_o and k unchanged.
- Latency from go handshake to core_in_valid_o = 1 SHALL be exactly 1 cycle.
- Latency from core result handshake to res_v_o = 1 SHALL be exactly 1 cycle.
REQ-021 core_out_valid_i asserted outside WAIT SHALL be ignored and SHALL NOT be captured.

Reset
REQ-022 On rst_i = 1 at a clock edge, the block SHALL reset as follows:
- State SHALL go to LOAD.
- pass, salt, iters, salt_len, the result register, k and the cycle counter SHALL all clear to 0.
REQ-023 All outputs SHALL read 0 during reset and in the cycle after it, except cfg_r_o, which SHALL read 1.
REQ-024 Reset asserted in ISSUE, WAIT or SEND SHALL abandon the job with no further core or result handshakes.

Configuration
REQ-025 The macro PBKDF2_HOST_CYCLE_CNT_EN SHALL control a cycle counter.
- Defined: a 32-bit counter clears on the ISSUE handshake and increments every cycle in WAIT, saturating at 0xFFFFFFFF.
- Defined: the stream SHALL carry 9 words, the 9th being the counter value, with res_last_o on word 8 (k is 4 bits).
- Undefined: no counter is built, the stream SHALL carry 8 words, and res_last_o SHALL be on word 7.

Verification
REQ-026 Directed scenario, full job: load 16 pass words 0x00000001..0x00000010, then salt words, iters = 2, go with data = 0x8.
- core_pass_o[511:480] = 0x1 and core_pass_o[31:0] = 0x10.
- core_salt_len_o = 8 and core_iters_o = 2 while core_in_valid_o = 1.
REQ-027 Directed scenario, rejected go: go with iters = 0 -> err_o high exactly 1 cycle, busy_o stays 0, and core_in_valid_o never asserts.
REQ-028 Directed scenario, core result: core returns hash 0x0011...EEFF (all 256 bits) -> word 0 = 0x00112233, word 7 = 0xCCDDEEFF, and res_last_o is on word 7 (macro undefined).
REQ-029 Directed scenario, result backpressure: hold res_r_i = 0 for 5 cycles mid-stream -> res_data_o is unchanged and no word is skipped or repeated.
REQ-030 Directed scenario, reset mid-job: assert rst_i in WAIT with core_out_valid_i = 1 -> no capture, and the next cycle shows LOAD with cfg_r_o = 1.
REQ-031 Directed scenario, cycle counter: with PBKDF2_HOST_CYCLE_CNT_EN defined and the core responding 10 cycles after the request handshake -> word 8 = 10 with res_last_o = 1.

Source files
------------

// File: rtl/pbkdf2_host.sv
// pbkdf2_host: collects a PBKDF2 job from 32-bit config words, issues it to the core and streams the derived key out.
// Define PBKDF2_HOST_CYCLE_CNT_EN to append the core latency in cycles as a ninth result word.
module pbkdf2_host (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cfg_v_i,
    output logic         cfg_r_o,
    input  logic [1:0]   cfg_sel_i,
    input  logic [31:0]  cfg_data_i,
    output logic         core_in_valid_o,
    input  logic         core_in_ready_i,
    output logic [31:0]  core_iters_o,
    output logic [511:0] core_pass_o,
    output logic [511:0] core_salt_o,
    output logic [5:0]   core_salt_len_o,
    input  logic         core_out_valid_i,
    output logic         core_out_ready_o,
    input  logic [255:0] core_hash_i,
    output logic         res_v_o,
    input  logic         res_r_i,
    output logic [31:0]  res_data_o,
    output logic         res_last_o,
    output logic         busy_o,
    output logic         err_o
);
`ifdef PBKDF2_HOST_CYCLE_CNT_EN
    localparam int KW = 4;
    localparam logic [KW-1:0] LAST = 4'd8;
`else
    localparam int KW = 3;
    localparam logic [KW-1:0] LAST = 3'd7;
`endif
    typedef enum logic [1:0] {LOAD, ISSUE, WAIT, SEND} state_t;
    state_t        r_state;
    logic [511:0]  r_pass;
    logic [511:0]  r_salt;
    logic [31:0]   r_iters;
    logic [5:0]    r_salt_len;
    logic [255:0]  r_hash;
    logic [KW-1:0] r_k;
    logic          r_err;
    logic [31:0]   w_words [8];
    for (genvar g = 0; g < 8; g++) begin : g_word
        assign w_words[g] = r_hash[255-32*g -: 32];
    end
    // Handshake outputs are masked while rst_i is high so an abandoned job cannot complete a transfer.
    assign cfg_r_o          = rst_i || r_state == LOAD;
    assign core_in_valid_o  = !rst_i && r_state == ISSUE;
    assign core_out_ready_o = !rst_i && r_state == WAIT;
    assign res_v_o          = !rst_i && r_state == SEND;
    assign res_last_o       = res_v_o && r_k == LAST;
    assign busy_o           = !rst_i && r_state != LOAD;
    assign err_o            = !rst_i && r_err;
    assign core_iters_o     = r_iters;
    assign core_pass_o      = r_pass;
    assign core_salt_o      = r_salt;
    assign core_salt_len_o  = r_salt_len;
`ifdef PBKDF2_HOST_CYCLE_CNT_EN
    logic [31:0] r_cnt;
    assign res_data_o = r_k[3] ? r_cnt : w_words[r_k[2:0]];
    always_ff @(posedge clk_i) begin
        if (rst_i || (core_in_valid_o && core_in_ready_i))
            r_cnt <= '0;
        else if (r_state == WAIT && r_cnt != '1)
            r_cnt <= r_cnt + 32'd1;
    end
`else
    assign res_data_o = w_words[r_k];
`endif
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= LOAD;
            r_pass     <= '0;
            r_salt     <= '0;
            r_iters    <= '0;
            r_salt_len <= '0;
            r_hash     <= '0;
            r_k        <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                LOAD: if (cfg_v_i) begin
                    if (cfg_sel_i == 2'd0) r_pass <= {r_pass[479:0], cfg_data_i};
                    if (cfg_sel_i == 2'd1) r_salt <= {r_salt[479:0], cfg_data_i};
                    if (cfg_sel_i == 2'd2) r_iters <= cfg_data_i;
                    if (cfg_sel_i == 2'd3) begin
                        r_salt_len <= cfg_data_i[5:0];
                        r_err      <= r_iters == '0;
                        r_state    <= r_iters == '0 ? LOAD : ISSUE;
                    end
                end
                ISSUE: if (core_in_ready_i) r_state <= WAIT;
                WAIT: if (core_out_valid_i) begin
                    r_hash  <= core_hash_i;
                    r_state <= SEND;
                end
                SEND: if (res_r_i) begin
                    r_k     <= r_k == LAST ? '0 : r_k + 1'b1;
                    r_state <= r_k == LAST ? LOAD : SEND;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pbkdf2_host.sv
// tb_pbkdf2_host: table-driven config vectors, directed corner cases and randomized jobs against a queue-based model.
module tb_pbkdf2_host;
`ifdef PBKDF2_HOST_CYCLE_CNT_EN
    localparam int NW = 9;
`else
    localparam int NW = 8;
`endif
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cfg_v_i;
    logic         cfg_r_o;
    logic [1:0]   cfg_sel_i;
    logic [31:0]  cfg_data_i;
    logic         core_in_valid_o;
    logic         core_in_ready_i;
    logic [31:0]  core_iters_o;
    logic [511:0] core_pass_o;
    logic [511:0] core_salt_o;
    logic [5:0]   core_salt_len_o;
    logic         core_out_valid_i;
    logic         core_out_ready_o;
    logic [255:0] core_hash_i;
    logic         res_v_o;
    logic         res_r_i;
    logic [31:0]  res_data_o;
    logic         res_last_o;
    logic         busy_o;
    logic         err_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_pass[$];
    logic [31:0] m_salt[$];
    logic [31:0] m_iters;
    logic [5:0]  m_len;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
        logic        err;
        logic        busy;
    } vec_t;
    vec_t tv[5];

    always #5 clk_i = ~clk_i;

    pbkdf2_host dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_v_i(cfg_v_i), .cfg_r_o(cfg_r_o), .cfg_sel_i(cfg_sel_i), .cfg_data_i(cfg_data_i),
        .core_in_valid_o(core_in_valid_o), .core_in_ready_i(core_in_ready_i),
        .core_iters_o(core_iters_o), .core_pass_o(core_pass_o), .core_salt_o(core_salt_o),
        .core_salt_len_o(core_salt_len_o),
        .core_out_valid_i(core_out_valid_i), .core_out_ready_o(core_out_ready_o), .core_hash_i(core_hash_i),
        .res_v_o(res_v_o), .res_r_i(res_r_i), .res_data_o(res_data_o), .res_last_o(res_last_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // The newest word sits in [31:0]; older words move up, only the last 16 survive.
    function automatic logic [511:0] vec(input logic [31:0] q[$]);
        logic [511:0] v = '0;
        for (int i = 0; i < q.size(); i++) v[32*i +: 32] = q[q.size()-1-i];
        return v;
    endfunction

    function automatic logic [31:0] exp_word(input logic [255:0] h, input int k, input int d);
        return k < 8 ? h[255-32*k -: 32] : d;
    endfunction

    task automatic tick;
        @(negedge clk_i);
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [31:0] d);
        chk("cfg_ready", cfg_r_o, 1);
        cfg_v_i = 1; cfg_sel_i = sel; cfg_data_i = d;
        tick;
        cfg_v_i = 0;
        case (sel)
            2'd0: begin m_pass.push_back(d); if (m_pass.size() > 16) void'(m_pass.pop_front()); end
            2'd1: begin m_salt.push_back(d); if (m_salt.size() > 16) void'(m_salt.pop_front()); end
            2'd2: m_iters = d;
            default: m_len = d[5:0];
        endcase
    endtask

    task automatic do_reset;
        rst_i = 1; cfg_v_i = 0; cfg_sel_i = 0; cfg_data_i = 0;
        core_in_ready_i = 0; core_out_valid_i = 0; core_hash_i = '0; res_r_i = 0;
        repeat (2) tick;
        chk("rst_cfg_r", cfg_r_o, 1);
        chk("rst_in_valid", core_in_valid_o, 0);
        chk("rst_res_v", res_v_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        rst_i = 0;
        #1;
        chk("post_cfg_r", cfg_r_o, 1);
        chk("post_out_ready", core_out_ready_o, 0);
        chk("post_pass", core_pass_o, 0);
        chk("post_salt", core_salt_o, 0);
        chk("post_iters", core_iters_o, 0);
        chk("post_len", core_salt_len_o, 0);
        chk("post_res_data", res_data_o, 0);
        chk("post_res_last", res_last_o, 0);
        chk("post_busy", busy_o, 0);
        m_pass.delete(); m_salt.delete(); m_iters = 0; m_len = 0;
    endtask

    // Entered one cycle after an accepted go; bp: 0 always ready, 1 random, 2 five-cycle stall on word 3.
    task automatic run_job(input logic [255:0] h, input int d, input int issue_stall, input int bp);
        int k = 0;
        int guard = 0;
        int hold = 0;
        chk("in_valid", core_in_valid_o, 1);
        chk("busy", busy_o, 1);
        chk("cfg_r_busy", cfg_r_o, 0);
        chk("pass", core_pass_o, vec(m_pass));
        chk("salt", core_salt_o, vec(m_salt));
        chk("iters", core_iters_o, m_iters);
        chk("salt_len", core_salt_len_o, m_len);
        core_out_valid_i = 1; core_hash_i = ~h;
        for (int i = 0; i < issue_stall; i++) begin
            tick;
            chk("in_hold", core_in_valid_o, 1);
            chk("pass_hold", core_pass_o, vec(m_pass));
            chk("out_ready_issue", core_out_ready_o, 0);
        end
        core_in_ready_i = 1;
        tick;
        core_in_ready_i = 0; core_out_valid_i = 0;
        chk("in_valid_wait", core_in_valid_o, 0);
        chk("out_ready", core_out_ready_o, 1);
        for (int i = 1; i < d; i++) tick;
        core_out_valid_i = 1; core_hash_i = h;
        tick;
        core_out_valid_i = 0; core_hash_i = ~h;
        chk("res_v_lat", res_v_o, 1);
        chk("out_ready_send", core_out_ready_o, 0);
        while (k < NW && guard < 200) begin
            res_r_i = bp == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bp == 2 && k == 3 && hold < 5) begin res_r_i = 0; hold++; end
            chk("res_v", res_v_o, 1);
            chk("res_data", res_data_o, exp_word(h, k, d));
            chk("res_last", res_last_o, k == NW - 1);
            tick;
            guard++;
            if (res_r_i) k++;
        end
        res_r_i = 0;
        chk("stream_words", k, NW);
        chk("end_cfg_r", cfg_r_o, 1);
        chk("end_busy", busy_o, 0);
        chk("end_res_v", res_v_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tv[0] = '{2'd2, 32'd0, 1'b0, 1'b0};
        tv[1] = '{2'd3, 32'd9, 1'b1, 1'b0};
        tv[2] = '{2'd2, 32'd3, 1'b0, 1'b0};
        tv[3] = '{2'd0, 32'hDEAD, 1'b0, 1'b0};
        tv[4] = '{2'd3, 32'd5, 1'b0, 1'b1};
        do_reset;
        for (int i = 0; i < 5; i++) begin
            cfg(tv[i].sel, tv[i].data);
            chk("tv_err", err_o, tv[i].err);
            chk("tv_busy", busy_o, tv[i].busy);
            chk("tv_in_valid", core_in_valid_o, tv[i].busy);
            chk("tv_len", core_salt_len_o, m_len);
        end
        do_reset;

        // Full job with a repeated 0x0011..EEFF pattern and a mid-stream stall.
        for (int i = 1; i <= 16; i++) cfg(2'd0, i);
        for (int i = 0; i < 4; i++) cfg(2'd1, 32'hA0 + i);
        cfg(2'd2, 2);
        cfg(2'd3, 8);
        chk("pass_first", core_pass_o[511:480], 32'h1);
        chk("pass_last", core_pass_o[31:0], 32'h10);
        chk("len_8", core_salt_len_o, 8);
        chk("iters_2", core_iters_o, 2);
        run_job(256'h00112233445566778899AABBCCDDEEFF00112233445566778899AABBCCDDEEFF, 3, 2, 2);

        // Retained job reruns; a 17th pass word drops the oldest.
        cfg(2'd0, 32'h11);
        chk("pass_17_hi", core_pass_o[511:480], 32'h2);
        cfg(2'd3, 8);
        run_job({8{32'hC0FFEE00}} ^ 256'h1, 10, 0, 0);

        // Reset in WAIT while the core offers a result.
        cfg(2'd2, 1);
        cfg(2'd3, 0);
        chk("mid_in_valid", core_in_valid_o, 1);
        core_in_ready_i = 1;
        tick;
        core_in_ready_i = 0;
        chk("mid_out_ready", core_out_ready_o, 1);
        core_out_valid_i = 1; core_hash_i = {8{32'h5A5A5A5A}}; rst_i = 1;
        #1;
        chk("mid_rst_out_ready", core_out_ready_o, 0);
        tick;
        chk("mid_rst_cfg_r", cfg_r_o, 1);
        rst_i = 0; core_out_valid_i = 0;
        #1;
        chk("mid_post_cfg_r", cfg_r_o, 1);
        chk("mid_post_busy", busy_o, 0);
        chk("mid_post_data", res_data_o, 0);
        m_pass.delete(); m_salt.delete(); m_iters = 0; m_len = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("mid_no_res", res_v_o, 0);
        end
        cfg(2'd2, 1);
        cfg(2'd3, 0);
        run_job({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1, 1, 0);

        for (int j = 0; j < 25; j++) begin
            int np;
            int ns;
            np = $urandom_range(0, 20);
            ns = $urandom_range(0, 20);
            if (j % 5 != 4) begin
                for (int i = 0; i < np; i++) cfg(2'd0, $urandom);
                for (int i = 0; i < ns; i++) cfg(2'd1, $urandom);
                cfg(2'd2, $urandom_range(0, 4) == 0 ? 32'd0 : $urandom);
            end
            cfg(2'd3, $urandom);
            if (m_iters == 0) begin
                chk("rnd_err", err_o, 1);
                chk("rnd_rej_busy", busy_o, 0);
                chk("rnd_rej_in_valid", core_in_valid_o, 0);
                tick;
                chk("rnd_err_pulse", err_o, 0);
            end else begin
                run_job({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                        $urandom_range(1, 12), $urandom_range(0, 3), 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
